// File: rtl/riscv_ctrl_pkg.sv
// Shared types, encodings and the instruction classifier for the multi-cycle
// RISC-V datapath sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    R    = 3'd0,
    ADDI = 3'd1,
    LD   = 3'd2,
    SD   = 3'd3,
    BEQ  = 3'd4,
    ILL  = 3'd5
  } op_class_e;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_SD   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  function automatic op_class_e decode_class(input logic [31:0] inst);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    op_class_e  cls;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    cls = ILL;
    case (opc)
      OPC_R: begin
        if (f3 == F3_ADD_SUB && (f7 == F7_BASE || f7 == F7_SUB)) cls = R;
        else if ((f3 == F3_AND || f3 == F3_OR) && f7 == F7_BASE) cls = R;
      end
      OPC_ADDI: if (f3 == F3_ADD_SUB) cls = ADDI;
      OPC_LD:   if (f3 == F3_DWORD)   cls = LD;
      OPC_SD:   if (f3 == F3_DWORD)   cls = SD;
      OPC_BEQ:  if (f3 == F3_BEQ)     cls = BEQ;
      default:  cls = ILL;
    endcase
    return cls;
  endfunction

  // ALU operation for the execute/writeback phases; R-type is resolved from funct fields.
  function automatic logic [1:0] alu_sel(input op_class_e cls, input logic [2:0] f3,
                                         input logic f7_sub);
    logic [1:0] op;
    op = ALU_ADD;
    case (cls)
      R: begin
        if (f3 == F3_AND)     op = ALU_AND;
        else if (f3 == F3_OR) op = ALU_OR;
        else if (f7_sub)      op = ALU_SUB;
        else                  op = ALU_ADD;
      end
      BEQ:     op = ALU_SUB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/datapath_controller_imm_gen.sv
// Immediate generator: assembles and sign-extends the I/S/B immediates from the
// instruction fields that carry them; R-type and illegal yield zero.
module imm_gen
  import riscv_ctrl_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic [11:0]     inst_hi_i,  // inst[31:20]
  input  logic [4:0]      inst_lo_i,  // inst[11:7]
  input  op_class_e       cls_i,
  output logic [BITS-1:0] imm_o
);

  logic [11:0] raw;

  always_comb begin
    raw = 12'd0;
    case (cls_i)
      ADDI, LD: raw = inst_hi_i;
      SD:       raw = {inst_hi_i[11:5], inst_lo_i};
      // Branch offset in halfwords; the datapath applies the final shift.
      BEQ:      raw = {inst_hi_i[11], inst_lo_i[0], inst_hi_i[10:5], inst_lo_i[4:1]};
      default:  raw = 12'd0;
    endcase
    imm_o = {{(BITS-12){raw[11]}}, raw};
  end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle control sequencer for the 64-bit RISC-V datapath.
// Optional perf counters (cycleCount/retired) when DATAPATH_CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | request instruction, latch it on fetchReady, watchdog running
// DECODE | classify latched instruction, register Imm
// EXEC   | drive ALU controls; beq retires here
// MEM    | data memory access, watchdog running; sd retires here
// WB     | register writeback; R/addi/ld retire here
// HALT   | sticky stop, left only by reset
module datapath_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int BITS    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instruction,
  input  logic            fetchReady,
  input  logic            dataReady,
  output logic            fetchReq,
  output logic            dataReq,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      ALUControl,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            Branch,
  output logic            MemToReg,
  output logic            ALUScr,
  output logic [BITS-1:0] Imm,
  output logic            halted,
  output logic            busErr
`ifdef DATAPATH_CTRL_PERF_EN
  ,
  output logic [63:0]     cycleCount,
  output logic [63:0]     retired
`endif
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WDG_LAST = WDW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [31:0]     ir_q;
  logic [BITS-1:0] imm_q, imm_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            bus_err_q, bus_err_d;
  op_class_e       cls;
  logic [1:0]      alu_op;
  logic            alu_src;

  assign cls     = decode_class(ir_q);
  assign alu_op  = alu_sel(cls, ir_q[14:12], ir_q[30]);
  assign alu_src = (cls == ADDI) || (cls == LD) || (cls == SD);

  imm_gen #(.BITS(BITS)) u_imm_gen (
    .inst_hi_i (ir_q[31:20]),
    .inst_lo_i (ir_q[11:7]),
    .cls_i     (cls),
    .imm_o     (imm_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= 32'd0;
      imm_q     <= '0;
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
      if (IRWrite) ir_q <= Instruction;
      if (state_q == DECODE) imm_q <= imm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    bus_err_d  = bus_err_q;
    fetchReq   = 1'b0;
    dataReq    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    MemToReg   = 1'b0;
    ALUScr     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        fetchReq = 1'b1;
        // Ready wins over an expiring watchdog in the same cycle.
        if (fetchReady) begin
          IRWrite = 1'b1;
          wdog_d  = '0;
          state_d = DECODE;
        end else if (wdog_q == WDG_LAST) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      DECODE: state_d = (cls == ILL) ? HALT : EXEC;
      EXEC: begin
        ALUControl = alu_op;
        ALUScr     = alu_src;
        case (cls)
          BEQ: begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
            state_d = FETCH;
          end
          R, ADDI: state_d = WB;
          LD, SD:  state_d = MEM;
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        dataReq    = 1'b1;
        ALUControl = ALU_ADD;
        ALUScr     = 1'b1;
        MemWrite   = (cls == SD);
        if (dataReady) begin
          wdog_d = '0;
          if (cls == SD) begin
            PCWrite = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wdog_q == WDG_LAST) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WB: begin
        ALUControl = alu_op;
        ALUScr     = alu_src;
        RegWrite   = 1'b1;
        MemToReg   = (cls == LD);
        PCWrite    = 1'b1;
        state_d    = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_d = HALT;
    endcase
  end

  assign Imm    = imm_q;
  assign busErr = bus_err_q;

`ifdef DATAPATH_CTRL_PERF_EN
  logic [63:0] cycle_cnt_q, retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 64'd0;
      retired_q   <= 64'd0;
    end else begin
      if (state_q != HALT) cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (PCWrite)         retired_q   <= retired_q + 64'd1;
    end
  end

  assign cycleCount = cycle_cnt_q;
  assign retired    = retired_q;
`endif

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: hand-computed expectations per phase.
module tb_datapath_controller;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instruction;
  logic        fetchReady, dataReady;
  logic        fetchReq, dataReq, IRWrite, PCWrite;
  logic [1:0]  ALUControl;
  logic        RegWrite, MemWrite, Branch, MemToReg, ALUScr;
  logic [63:0] Imm;
  logic        halted, busErr;
`ifdef DATAPATH_CTRL_PERF_EN
  logic [63:0] cycleCount, retired;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  datapath_controller #(.BITS(64), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Instruction(Instruction),
    .fetchReady (fetchReady),
    .dataReady  (dataReady),
    .fetchReq   (fetchReq),
    .dataReq    (dataReq),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .MemToReg   (MemToReg),
    .ALUScr     (ALUScr),
    .Imm        (Imm),
    .halted     (halted),
    .busErr     (busErr)
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    .cycleCount (cycleCount),
    .retired    (retired)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetchReady = 1'b0;
    dataReady = 1'b0;
    Instruction = 32'd0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Present an instruction with fetchReady for one FETCH cycle; ends in DECODE.
  task automatic fetch(input logic [31:0] inst);
    Instruction = inst;
    fetchReady = 1'b1;
    #1;
    chk("fetch_irwrite", {63'd0, IRWrite}, 64'd1);
    tick();
    fetchReady = 1'b0;
    chk("decode_no_req", {63'd0, fetchReq}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    fetchReady = 1'b0;
    dataReady = 1'b0;
    Instruction = 32'd0;
    #2;
    do_reset();

    chk("rst_fetchReq", {63'd0, fetchReq}, 64'd1);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_busErr", {63'd0, busErr}, 64'd0);
    chk("rst_imm", Imm, 64'd0);
    chk("rst_pcwrite", {63'd0, PCWrite}, 64'd0);

    // add x3,x1,x2
    fetch(32'h002081B3);
    tick();
    chk("add_exec_alu", {62'd0, ALUControl}, 64'd0);
    chk("add_exec_src", {63'd0, ALUScr}, 64'd0);
    chk("add_exec_imm", Imm, 64'd0);
    tick();
    chk("add_wb_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("add_wb_pcwrite", {63'd0, PCWrite}, 64'd1);
    chk("add_wb_memtoreg", {63'd0, MemToReg}, 64'd0);
    tick();
    chk("add_back_fetch", {63'd0, fetchReq}, 64'd1);
`ifdef DATAPATH_CTRL_PERF_EN
    chk("perf_cycles_add", cycleCount, 64'd4);
    chk("perf_retired_add", retired, 64'd1);
`endif

    // sub x3,x1,x2
    fetch(32'h402081B3);
    tick();
    chk("sub_exec_alu", {62'd0, ALUControl}, 64'd1);
    tick();
    chk("sub_wb_alu_held", {62'd0, ALUControl}, 64'd1);
    tick();

    // and x3,x1,x2 / or x3,x1,x2
    fetch(32'h0020F1B3);
    tick();
    chk("and_exec_alu", {62'd0, ALUControl}, 64'd2);
    tick();
    tick();
    fetch(32'h0020E1B3);
    tick();
    chk("or_exec_alu", {62'd0, ALUControl}, 64'd3);
    tick();
    tick();

    // addi x1,x1,10
    fetch(32'h00A08093);
    tick();
    chk("addi_imm", Imm, 64'd10);
    chk("addi_src", {63'd0, ALUScr}, 64'd1);
    tick();
    chk("addi_wb_regwrite", {63'd0, RegWrite}, 64'd1);
    tick();

    // ld x5,-8(x2), dataReady after 3 waiting MEM cycles
    fetch(32'hFF813283);
    tick();
    chk("ld_imm", Imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ld_exec_src", {63'd0, ALUScr}, 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_req", {63'd0, dataReq}, 64'd1);
      chk("ld_mem_nowrite", {63'd0, MemWrite}, 64'd0);
      tick();
    end
    chk("ld_mem_req4", {63'd0, dataReq}, 64'd1);
    dataReady = 1'b1;
    #1;
    chk("ld_mem_no_pcwrite", {63'd0, PCWrite}, 64'd0);
    tick();
    dataReady = 1'b0;
    chk("ld_wb_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("ld_wb_memtoreg", {63'd0, MemToReg}, 64'd1);
    chk("ld_wb_pcwrite", {63'd0, PCWrite}, 64'd1);
    tick();

    // sd x5,16(x2)
    fetch(32'h00513823);
    tick();
    chk("sd_imm", Imm, 64'd16);
    chk("sd_exec_regwrite", {63'd0, RegWrite}, 64'd0);
    tick();
    chk("sd_mem_memwrite", {63'd0, MemWrite}, 64'd1);
    chk("sd_mem_req", {63'd0, dataReq}, 64'd1);
    chk("sd_mem_regwrite", {63'd0, RegWrite}, 64'd0);
    dataReady = 1'b1;
    #1;
    chk("sd_mem_pcwrite", {63'd0, PCWrite}, 64'd1);
    tick();
    dataReady = 1'b0;
    chk("sd_back_fetch", {63'd0, fetchReq}, 64'd1);
    chk("sd_fetch_regwrite", {63'd0, RegWrite}, 64'd0);

    // beq x1,x2,-4
    fetch(32'hFE208EE3);
    tick();
    chk("beq_imm", Imm, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("beq_branch", {63'd0, Branch}, 64'd1);
    chk("beq_alu", {62'd0, ALUControl}, 64'd1);
    chk("beq_pcwrite", {63'd0, PCWrite}, 64'd1);
    tick();
    chk("beq_back_fetch", {63'd0, fetchReq}, 64'd1);

    // Illegal all-zero instruction
    fetch(32'h00000000);
    tick();
    chk("ill_halted", {63'd0, halted}, 64'd1);
    chk("ill_busErr", {63'd0, busErr}, 64'd0);
    chk("ill_no_fetch", {63'd0, fetchReq}, 64'd0);
    fetchReady = 1'b1;
    tick();
    tick();
    fetchReady = 1'b0;
    chk("ill_sticky", {63'd0, halted}, 64'd1);

    // Fetch timeout: 16 FETCH cycles without ready
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    chk("to_still_fetch", {63'd0, fetchReq}, 64'd1);
    chk("to_not_halted", {63'd0, halted}, 64'd0);
    tick();
    chk("to_halted", {63'd0, halted}, 64'd1);
    chk("to_busErr", {63'd0, busErr}, 64'd1);

    // Ready on the expiring watchdog cycle wins
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    fetch(32'h002081B3);
    chk("race_not_halted", {63'd0, halted}, 64'd0);
    chk("race_busErr", {63'd0, busErr}, 64'd0);
    tick();
    tick();
    tick();

    // Asynchronous reset in the middle of a store
    fetch(32'h00513823);
    tick();
    tick();
    chk("mid_mem_req", {63'd0, dataReq}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dataReq", {63'd0, dataReq}, 64'd0);
    chk("arst_memwrite", {63'd0, MemWrite}, 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_fetchReq", {63'd0, fetchReq}, 64'd1);
    chk("arst_imm", Imm, 64'd0);
`ifdef DATAPATH_CTRL_PERF_EN
    chk("arst_cycles", cycleCount, 64'd0);
    chk("arst_retired", retired, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
